// File: rtl/shift_step_reg.sv
// Stepped arithmetic right-shift register: loads a value, then on each enabled
// step captures step_in >>> SHIFT_AMT until STEPS steps have been accepted.
module shift_step_reg #(
  parameter int WIDTH     = 65,
  parameter int SHIFT_AMT = 2,
  parameter int STEPS     = 16,
  localparam int CW       = $clog2(STEPS+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step_in,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    step_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] shifted;

  assign shifted = WIDTH'($signed(step_in) >>> SHIFT_AMT);
  assign cnt_inc = step_cnt + CW'(1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      q        <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      step_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = step_cnt;
    if (flush) begin
      // abort wins over start/en; leaving DONE/RUN here means no done pulse follows
      state_nxt = IDLE;
      q_nxt     = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = RUN;
            q_nxt     = load_val;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        RUN: begin
          if (en) begin
            q_nxt   = shifted;
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(STEPS)) state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_step_reg.sv
// Directed bench for shift_step_reg at WIDTH=65, SHIFT_AMT=2, STEPS=16.
module tb_shift_step_reg;
  localparam int WIDTH = 65;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             clr, start, en, flush;
  logic [WIDTH-1:0] load_val, step_in, q;
  logic             busy, done;
  logic [CW-1:0]    step_cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  shift_step_reg #(.WIDTH(WIDTH), .SHIFT_AMT(2), .STEPS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .load_val(load_val), .step_in(step_in),
    .en(en), .flush(flush), .q(q), .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // advance one rising edge, sample 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; en = 1'b0; flush = 1'b0;
    load_val = '0; step_in = '0;
    #12;
    tot_cnt++; if (q !== '0) $display("FAIL reset_q got %h exp 0", q); else pass_cnt++;
    tot_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {busy, done}); else pass_cnt++;
    tot_cnt++; if (step_cnt !== '0) $display("FAIL reset_cnt got %0d exp 0", step_cnt); else pass_cnt++;
    tick();
    clr = 1'b1;
    start = 1'b1; load_val = 65'h5;
    tick();
    start = 1'b0;
    tot_cnt++; if (q !== 65'h5 || busy !== 1'b1) $display("FAIL load5 q %h busy %b exp 5/1", q, busy); else pass_cnt++;
    #2 clr = 1'b0;
    #1;
    tot_cnt++; if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== '0)
      $display("FAIL async_clr q %h busy %b done %b cnt %0d exp 0/0/0/0", q, busy, done, step_cnt);
    else pass_cnt++;
    tick();
    clr = 1'b1;
    tick();
    tot_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_clr busy %b done %b exp 0/0", busy, done); else pass_cnt++;
  endtask

  task automatic test_basic();
    start = 1'b1; load_val = 65'h5; step_in = -65'sd8; en = 1'b1;
    tick();
    start = 1'b0;
    tot_cnt++; if (q !== 65'h5 || step_cnt !== 0 || busy !== 1'b1) $display("FAIL basic_load q %h cnt %0d busy %b exp 5/0/1", q, step_cnt, busy); else pass_cnt++;
    tick();
    tot_cnt++; if (q !== -65'sd2 || step_cnt !== 1) $display("FAIL basic_step1 q %h cnt %0d exp -2/1", q, step_cnt); else pass_cnt++;
    repeat (14) tick();
    tot_cnt++; if (step_cnt !== 15 || busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_step15 cnt %0d busy %b done %b exp 15/1/0", step_cnt, busy, done); else pass_cnt++;
    tick();
    tot_cnt++; if (done !== 1'b1 || busy !== 1'b0 || step_cnt !== 16 || q !== -65'sd2)
      $display("FAIL basic_done done %b busy %b cnt %0d q %h exp 1/0/16/-2", done, busy, step_cnt, q);
    else pass_cnt++;
    tick();
    tot_cnt++; if (done !== 1'b0 || busy !== 1'b0 || step_cnt !== 16 || q !== -65'sd2)
      $display("FAIL basic_idle done %b busy %b cnt %0d q %h exp 0/0/16/-2", done, busy, step_cnt, q);
    else pass_cnt++;
  endtask

  task automatic test_msb();
    start = 1'b1; load_val = 65'h0; step_in = 65'h1_0000_0000_0000_0004; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tot_cnt++; if (q !== 65'h1_C000_0000_0000_0001) $display("FAIL msb_repl got %h exp 1c000000000000001", q); else pass_cnt++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tot_cnt++; if (q !== '0 || step_cnt !== 0 || busy !== 1'b0) $display("FAIL msb_flush q %h cnt %0d busy %b exp 0/0/0", q, step_cnt, busy); else pass_cnt++;
  endtask

  // stall, then back-to-back restart from DONE, then flush+start mid-run
  task automatic test_stall_b2b_flush();
    int seen_done;
    start = 1'b1; load_val = 65'h0; step_in = 65'h100; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tot_cnt++; if (q !== 65'h40 || step_cnt !== 1) $display("FAIL stall_step q %h cnt %0d exp 40/1", q, step_cnt); else pass_cnt++;
    en = 1'b0;
    tick(); tick();
    tot_cnt++; if (q !== 65'h40 || step_cnt !== 1 || busy !== 1'b1) $display("FAIL stall_hold q %h cnt %0d busy %b exp 40/1/1", q, step_cnt, busy); else pass_cnt++;
    en = 1'b1; step_in = 65'h200;
    tick();
    tot_cnt++; if (q !== 65'h80 || step_cnt !== 2) $display("FAIL stall_resume q %h cnt %0d exp 80/2", q, step_cnt); else pass_cnt++;
    repeat (14) tick();
    start = 1'b1; load_val = 65'h7;
    #1;
    tot_cnt++; if (done !== 1'b1 || step_cnt !== 16) $display("FAIL b2b_done done %b cnt %0d exp 1/16", done, step_cnt); else pass_cnt++;
    tick();
    start = 1'b0; step_in = 65'h40;
    tot_cnt++; if (busy !== 1'b1 || done !== 1'b0 || q !== 65'h7 || step_cnt !== 0)
      $display("FAIL b2b_restart busy %b done %b q %h cnt %0d exp 1/0/7/0", busy, done, q, step_cnt);
    else pass_cnt++;
    repeat (9) tick();
    tot_cnt++; if (step_cnt !== 9 || q !== 65'h10) $display("FAIL pre_flush cnt %0d q %h exp 9/10", step_cnt, q); else pass_cnt++;
    flush = 1'b1; start = 1'b1; load_val = 65'h3;
    tick();
    flush = 1'b0; start = 1'b0;
    tot_cnt++; if (busy !== 1'b0 || q !== '0 || step_cnt !== 0 || done !== 1'b0)
      $display("FAIL flush busy %b q %h cnt %0d done %b exp 0/0/0/0", busy, q, step_cnt, done);
    else pass_cnt++;
    seen_done = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    tot_cnt++; if (seen_done !== 0) $display("FAIL flush_no_done got %0d active cycles exp 0", seen_done); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    start = 1'b1; load_val = 65'h10; step_in = 65'h40; en = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    tot_cnt++; if (step_cnt !== 3 || q !== 65'h10) $display("FAIL ign_pre cnt %0d q %h exp 3/10", step_cnt, q); else pass_cnt++;
    start = 1'b1; load_val = 65'h999;
    tick();
    start = 1'b0;
    tot_cnt++; if (step_cnt !== 4 || q !== 65'h10 || busy !== 1'b1) $display("FAIL ign_start cnt %0d q %h busy %b exp 4/10/1", step_cnt, q, busy); else pass_cnt++;
    repeat (11) tick();
    tot_cnt++; if (step_cnt !== 15 || done !== 1'b0) $display("FAIL ign_15 cnt %0d done %b exp 15/0", step_cnt, done); else pass_cnt++;
    tick();
    tot_cnt++; if (done !== 1'b1 || step_cnt !== 16) $display("FAIL ign_done done %b cnt %0d exp 1/16", done, step_cnt); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb();
    test_stall_b2b_flush();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
